// File: rtl/rgb2gray_loader.sv
// RGB stream -> 8-bit luminance loader feeding the Sobel input-image RAM.
// Optional macro GRAY_ROUND_EN selects round-to-nearest instead of floor conversion.
module rgb2gray_loader #(
  parameter int DATA_WIDTH        = 8,
  parameter int ADDR_WIDTH        = 16,
  parameter int IMAGE_ROW_SIZE    = 64,
  parameter int IMAGE_COLUMN_SIZE = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    arm_i,
  input  logic                    s_valid_i,
  input  logic [3*DATA_WIDTH-1:0] s_rgb_i,
  output logic                    s_ready_o,
  output logic                    wr_en_o,
  output logic [ADDR_WIDTH-1:0]   wr_addr_o,
  output logic [DATA_WIDTH-1:0]   wr_data_o,
  output logic                    start_o,
  input  logic                    finish_i,
  output logic                    busy_o,
  output logic                    frame_done_o
);
  localparam int N   = IMAGE_ROW_SIZE * IMAGE_COLUMN_SIZE;
  localparam int CW  = $clog2(N) + 1;
  localparam int SW  = 2 * DATA_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_START, S_WAIT_FIN} state_t;

  state_t                r_state;
  logic [CW-1:0]         r_pix_cnt;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_start;

  logic [DATA_WIDTH-1:0] w_r, w_g, w_b;
  logic [SW-1:0]         w_sum;
  logic [DATA_WIDTH-1:0] w_gray;
  logic                  w_hs;

  assign w_r = s_rgb_i[3*DATA_WIDTH-1:2*DATA_WIDTH];
  assign w_g = s_rgb_i[2*DATA_WIDTH-1:DATA_WIDTH];
  assign w_b = s_rgb_i[DATA_WIDTH-1:0];

  // Weights sum to 256, so the 2*DATA_WIDTH accumulator cannot overflow.
`ifdef GRAY_ROUND_EN
  assign w_sum = SW'(77) * SW'(w_r) + SW'(150) * SW'(w_g) + SW'(29) * SW'(w_b) + SW'(128);
`else
  assign w_sum = SW'(77) * SW'(w_r) + SW'(150) * SW'(w_g) + SW'(29) * SW'(w_b);
`endif
  assign w_gray = DATA_WIDTH'(w_sum >> 8);

  assign s_ready_o    = (r_state == S_LOAD) && (r_pix_cnt < CW'(N));
  assign w_hs         = s_valid_i && s_ready_o;
  assign busy_o       = (r_state != S_IDLE);
  assign frame_done_o = (r_state == S_WAIT_FIN) && finish_i;
  assign wr_en_o      = r_wr_en;
  assign wr_addr_o    = r_wr_addr;
  assign wr_data_o    = r_wr_data;
  assign start_o      = r_start;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_pix_cnt <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_start   <= 1'b0;
    end else begin
      r_wr_en <= w_hs;
      r_start <= 1'b0;
      if (w_hs) begin
        r_wr_addr <= ADDR_WIDTH'(r_pix_cnt);
        r_wr_data <= w_gray;
      end
      case (r_state)
        S_IDLE: begin
          r_pix_cnt <= '0;
          if (arm_i) r_state <= S_LOAD;
        end
        S_LOAD: begin
          if (w_hs) begin
            r_pix_cnt <= r_pix_cnt + CW'(1);
            if (r_pix_cnt == CW'(N - 1)) r_state <= S_DRAIN;
          end
        end
        // Final write retires here; start is registered so it lands in S_START.
        S_DRAIN: begin
          r_state <= S_START;
          r_start <= 1'b1;
        end
        S_START:    r_state <= S_WAIT_FIN;
        S_WAIT_FIN: if (finish_i) r_state <= S_IDLE;
        default:    r_state <= S_IDLE;
      endcase
    end
  end
endmodule
